// File: rtl/spn_req_sequencer.sv
// Request front-end for the 3-round SPN core: queues requests, issues one opcode
// pulse per request, captures the core's reply and returns it on a valid/ready port.
//
// state   | meaning
// IDLE    | waiting for a queued request; pops the FIFO head when one is present
// ISSUE   | opcode driven to the core for this single cycle
// CAPTURE | core reply present on its outputs; sampled into the response registers
// HOLD    | response held stable until the downstream accepts it
module spn_req_sequencer #(
    parameter int DEPTH = 4,
    parameter int ERRW  = 8
) (
    input  logic                       i_clk,
    input  logic                       i_rst,
    input  logic                       i_req_valid,
    output logic                       o_req_ready,
    input  logic [1:0]                 i_req_op,
    input  logic [15:0]                i_req_data,
    input  logic [31:0]                i_req_key,
    output logic [1:0]                 o_core_opcode,
    output logic [15:0]                o_core_data_in,
    output logic [31:0]                o_core_key,
    input  logic [1:0]                 i_core_valid,
    input  logic [15:0]                i_core_data_out,
    output logic                       o_rsp_valid,
    input  logic                       i_rsp_ready,
    output logic [15:0]                o_rsp_data,
    output logic [1:0]                 o_rsp_op,
    output logic                       o_rsp_err,
    output logic [ERRW-1:0]            o_err_count,
    output logic [$clog2(DEPTH+1)-1:0] o_fifo_count,
    output logic                       o_busy
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);
    localparam int EW = 50;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ISSUE   = 2'd1,
        CAPTURE = 2'd2,
        HOLD    = 2'd3
    } state_t;

    state_t          r_state;
    state_t          w_state_nxt;

    logic [EW-1:0]   r_mem [DEPTH];
    logic [AW-1:0]   r_wr_ptr;
    logic [AW-1:0]   r_rd_ptr;
    logic [CW-1:0]   r_count;

    logic [1:0]      r_core_opcode;
    logic [15:0]     r_core_data_in;
    logic [31:0]     r_core_key;
    logic [1:0]      r_issued_op;
    logic            r_rsp_valid;
    logic [15:0]     r_rsp_data;
    logic [1:0]      r_rsp_op;
    logic            r_rsp_err;
    logic [ERRW-1:0] r_err_count;

    logic [EW-1:0]   w_head;
    logic [1:0]      w_head_op;
    logic [15:0]     w_head_data;
    logic [31:0]     w_head_key;
    logic            w_push;
    logic            w_pop;
    logic            w_issue;
    logic            w_illegal;
    logic            w_capture;
    logic            w_rsp_done;
    logic            w_cap_err;
    logic            w_load_err;

    assign w_head      = r_mem[r_rd_ptr];
    assign w_head_op   = w_head[49:48];
    assign w_head_data = w_head[47:32];
    assign w_head_key  = w_head[31:0];

    // No pass-through: a full FIFO refuses the offer even if the head pops this cycle.
    assign o_req_ready = (r_count != CW'(DEPTH));
    assign w_push      = i_req_valid && o_req_ready;
    assign w_pop       = (r_state == IDLE) && (r_count != '0);

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
            if (w_push && !w_pop)      r_count <= r_count + CW'(1);
            else if (w_pop && !w_push) r_count <= r_count - CW'(1);
        end
    end

    always_ff @(posedge i_clk) begin
        if (w_push) r_mem[r_wr_ptr] <= {i_req_op, i_req_data, i_req_key};
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) r_state <= IDLE;
        else       r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (w_pop) w_state_nxt = (w_head_op == 2'b00) ? HOLD : ISSUE;
            ISSUE:   w_state_nxt = CAPTURE;
            CAPTURE: w_state_nxt = HOLD;
            HOLD:    if (i_rsp_ready) w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_comb begin
        w_issue    = 1'b0;
        w_illegal  = 1'b0;
        w_capture  = 1'b0;
        w_rsp_done = 1'b0;
        case (r_state)
            IDLE: begin
                w_issue   = w_pop && (w_head_op != 2'b00);
                w_illegal = w_pop && (w_head_op == 2'b00);
            end
            CAPTURE: w_capture  = 1'b1;
            HOLD:    w_rsp_done = i_rsp_ready;
            default: ;
        endcase
    end

    // Op 11 is sent to the core on purpose but always reported as an error.
    assign w_cap_err  = (r_issued_op == 2'b11) || (i_core_valid != r_issued_op);
    assign w_load_err = w_illegal || (w_capture && w_cap_err);

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_core_opcode  <= 2'b00;
            r_core_data_in <= '0;
            r_core_key     <= '0;
            r_issued_op    <= 2'b00;
            r_rsp_valid    <= 1'b0;
            r_rsp_data     <= '0;
            r_rsp_op       <= 2'b00;
            r_rsp_err      <= 1'b0;
            r_err_count    <= '0;
        end else begin
            r_core_opcode <= w_issue ? w_head_op : 2'b00;
            if (w_issue) begin
                r_core_data_in <= w_head_data;
                r_core_key     <= w_head_key;
                r_issued_op    <= w_head_op;
            end
            if (w_illegal) begin
                r_rsp_valid <= 1'b1;
                r_rsp_data  <= '0;
                r_rsp_op    <= 2'b00;
                r_rsp_err   <= 1'b1;
            end else if (w_capture) begin
                r_rsp_valid <= 1'b1;
                r_rsp_data  <= w_cap_err ? 16'h0000 : i_core_data_out;
                r_rsp_op    <= r_issued_op;
                r_rsp_err   <= w_cap_err;
            end else if (w_rsp_done) begin
                r_rsp_valid <= 1'b0;
            end
            if (w_load_err && (r_err_count != '1)) r_err_count <= r_err_count + ERRW'(1);
        end
    end

    assign o_core_opcode  = r_core_opcode;
    assign o_core_data_in = r_core_data_in;
    assign o_core_key     = r_core_key;
    assign o_rsp_valid    = r_rsp_valid;
    assign o_rsp_data     = r_rsp_data;
    assign o_rsp_op       = r_rsp_op;
    assign o_rsp_err      = r_rsp_err;
    assign o_err_count    = r_err_count;
    assign o_fifo_count   = r_count;
    assign o_busy         = (r_state != IDLE) || (r_count != '0);

endmodule

// File: tb/tb_spn_req_sequencer.sv
// Bench for spn_req_sequencer: directed scenarios plus random traffic, with a
// behavioural SPN core and an in-order response queue as the reference.
module tb_spn_req_sequencer;

    localparam int          DEPTH = 4;
    localparam logic [31:0] KEY1  = 32'hA1B2C3D4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        req_valid;
    logic        rsp_ready;
    logic [1:0]  req_op;
    logic [15:0] req_data;
    logic [31:0] req_key;

    logic        req_ready, rsp_valid, rsp_err, busy;
    logic [1:0]  core_opcode, rsp_op;
    logic [15:0] core_data_in, rsp_data;
    logic [31:0] core_key;
    logic [7:0]  err_count;
    logic [2:0]  fifo_count;
    logic [1:0]  core_valid = 2'b00;
    logic [15:0] core_data_out = 16'h0;

    logic        req_ready_s, rsp_valid_s, rsp_err_s, busy_s;
    logic [1:0]  core_opcode_s, rsp_op_s;
    logic [15:0] core_data_in_s, rsp_data_s;
    logic [31:0] core_key_s;
    logic [1:0]  err_count_s;
    logic [2:0]  fifo_count_s;
    logic [1:0]  core_valid_s = 2'b00;
    logic [15:0] core_data_out_s = 16'h0;

    logic core_fault = 1'b0;

    spn_req_sequencer #(.DEPTH(DEPTH), .ERRW(8)) dut (
        .i_clk(clk), .i_rst(rst), .i_req_valid(req_valid), .o_req_ready(req_ready),
        .i_req_op(req_op), .i_req_data(req_data), .i_req_key(req_key),
        .o_core_opcode(core_opcode), .o_core_data_in(core_data_in), .o_core_key(core_key),
        .i_core_valid(core_valid), .i_core_data_out(core_data_out),
        .o_rsp_valid(rsp_valid), .i_rsp_ready(rsp_ready), .o_rsp_data(rsp_data),
        .o_rsp_op(rsp_op), .o_rsp_err(rsp_err), .o_err_count(err_count),
        .o_fifo_count(fifo_count), .o_busy(busy)
    );

    spn_req_sequencer #(.DEPTH(DEPTH), .ERRW(2)) dut_s (
        .i_clk(clk), .i_rst(rst), .i_req_valid(req_valid), .o_req_ready(req_ready_s),
        .i_req_op(req_op), .i_req_data(req_data), .i_req_key(req_key),
        .o_core_opcode(core_opcode_s), .o_core_data_in(core_data_in_s), .o_core_key(core_key_s),
        .i_core_valid(core_valid_s), .i_core_data_out(core_data_out_s),
        .o_rsp_valid(rsp_valid_s), .i_rsp_ready(rsp_ready), .o_rsp_data(rsp_data_s),
        .o_rsp_op(rsp_op_s), .o_rsp_err(rsp_err_s), .o_err_count(err_count_s),
        .o_fifo_count(fifo_count_s), .o_busy(busy_s)
    );

    // ---------------- golden 3-round SPN ----------------
    function automatic logic [3:0] sbox(input logic [3:0] n);
        logic [63:0] t;
        t = 64'hC56B90AD3EF84712;
        return t[4*(15-int'(n)) +: 4];
    endfunction

    function automatic logic [3:0] sbox_inv(input logic [3:0] n);
        for (int i = 0; i < 16; i++) if (sbox(4'(i)) == n) return 4'(i);
        return 4'h0;
    endfunction

    function automatic int pbit(input int i);
        return (i == 15) ? 15 : (i * 4) % 15;
    endfunction

    function automatic logic [15:0] sub16(input logic [15:0] x, input logic inv);
        logic [15:0] y;
        for (int i = 0; i < 4; i++) y[4*i +: 4] = inv ? sbox_inv(x[4*i +: 4]) : sbox(x[4*i +: 4]);
        return y;
    endfunction

    function automatic logic [15:0] perm16(input logic [15:0] x, input logic inv);
        logic [15:0] y;
        y = 16'h0;
        for (int i = 0; i < 16; i++) begin
            if (inv) y[i] = x[pbit(i)];
            else     y[pbit(i)] = x[i];
        end
        return y;
    endfunction

    function automatic logic [15:0] rkey(input logic [31:0] k, input int r);
        case (r)
            0:       return k[15:0];
            1:       return k[31:16];
            2:       return k[15:0] ^ k[31:16];
            default: return {k[7:0], k[31:24]};
        endcase
    endfunction

    function automatic logic [15:0] spn_enc(input logic [15:0] d, input logic [31:0] k);
        logic [15:0] x;
        x = d;
        for (int r = 0; r < 3; r++) begin
            x = sub16(x ^ rkey(k, r), 1'b0);
            if (r < 2) x = perm16(x, 1'b0);
        end
        return x ^ rkey(k, 3);
    endfunction

    function automatic logic [15:0] spn_dec(input logic [15:0] d, input logic [31:0] k);
        logic [15:0] x;
        x = d ^ rkey(k, 3);
        for (int r = 2; r >= 0; r--) begin
            if (r < 2) x = perm16(x, 1'b1);
            x = sub16(x, 1'b1) ^ rkey(k, r);
        end
        return x;
    endfunction

    function automatic logic [15:0] core_fn(input logic [1:0] op, input logic [15:0] d, input logic [31:0] k);
        case (op)
            2'b01:   return spn_enc(d, k);
            2'b10:   return spn_dec(d, k);
            2'b11:   return 16'hFFFF;
            default: return 16'h0000;
        endcase
    endfunction

    // Core stand-in: registered reply one cycle after the opcode; fault corrupts valid.
    always @(posedge clk) begin
        core_valid      <= core_fault ? (core_opcode ^ 2'b11) : core_opcode;
        core_data_out   <= core_fn(core_opcode, core_data_in, core_key);
        core_valid_s    <= core_fault ? (core_opcode_s ^ 2'b11) : core_opcode_s;
        core_data_out_s <= core_fn(core_opcode_s, core_data_in_s, core_key_s);
    end

    // ---------------- reference model ----------------
    typedef struct packed {
        logic [15:0] data;
        logic [1:0]  op;
        logic        err;
    } rsp_t;

    rsp_t exp_q[$];
    int   errs_consumed = 0;
    int   total = 0;
    int   bad = 0;
    int   pulses;
    logic [15:0] last_data;
    logic        last_err;
    logic [15:0] ct;
    logic [1:0]  prev_opc;
    logic        acc, cons;
    int          r;

    function automatic rsp_t model_rsp(input logic [1:0] op, input logic [15:0] d,
                                       input logic [31:0] k, input logic fault);
        rsp_t e;
        e.op   = op;
        e.err  = (op == 2'b00) || (op == 2'b11) || fault;
        e.data = e.err ? 16'h0000 : ((op == 2'b01) ? spn_enc(d, k) : spn_dec(d, k));
        return e;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_front(input string tag);
        rsp_t e;
        int   n;
        if (exp_q.size() == 0) begin
            chk({tag, "_unexpected_rsp"}, 64'(rsp_valid), 64'd0);
            return;
        end
        e = exp_q[0];
        n = errs_consumed + int'(e.err);
        chk({tag, "_data"},    64'(rsp_data),    64'(e.data));
        chk({tag, "_op"},      64'(rsp_op),      64'(e.op));
        chk({tag, "_err"},     64'(rsp_err),     64'(e.err));
        chk({tag, "_errcnt"},  64'(err_count),   64'((n > 255) ? 255 : n));
        chk({tag, "_s_valid"}, 64'(rsp_valid_s), 64'd1);
        chk({tag, "_s_data"},  64'(rsp_data_s),  64'(e.data));
        chk({tag, "_s_op"},    64'(rsp_op_s),    64'(e.op));
        chk({tag, "_s_err"},   64'(rsp_err_s),   64'(e.err));
        chk({tag, "_s_errcnt"},64'(err_count_s), 64'((n > 3) ? 3 : n));
    endtask

    task automatic consume();
        rsp_t e;
        if (exp_q.size() == 0) return;
        e = exp_q.pop_front();
        errs_consumed += int'(e.err);
    endtask

    task automatic push(input logic [1:0] op, input logic [15:0] d, input logic [31:0] k);
        int w;
        w = 0;
        while (!req_ready && w < 100) begin
            tick();
            w++;
        end
        if (!req_ready) begin
            chk("push_timeout", 64'(req_ready), 64'd1);
            return;
        end
        req_valid = 1'b1;
        req_op    = op;
        req_data  = d;
        req_key   = k;
        tick();
        req_valid = 1'b0;
        exp_q.push_back(model_rsp(op, d, k, core_fault));
    endtask

    task automatic take_rsp(input string tag);
        int w;
        w = 0;
        pulses = 0;
        rsp_ready = 1'b1;
        while (!rsp_valid && w < 50) begin
            if (core_opcode != 2'b00) pulses++;
            tick();
            w++;
        end
        if (!rsp_valid) begin
            chk({tag, "_timeout"}, 64'(rsp_valid), 64'd1);
            return;
        end
        check_front(tag);
        last_data = rsp_data;
        last_err  = rsp_err;
        tick();
        consume();
    endtask

    initial begin
        rst = 1'b1; req_valid = 1'b0; rsp_ready = 1'b0;
        req_op = 2'b00; req_data = 16'h0; req_key = 32'h0;
        tick();
        tick();
        rst = 1'b0;
        chk("rst_rsp_valid", 64'(rsp_valid),   64'd0);
        chk("rst_opcode",    64'(core_opcode), 64'd0);
        chk("rst_fifo",      64'(fifo_count),  64'd0);
        chk("rst_busy",      64'(busy),        64'd0);
        chk("rst_req_ready", 64'(req_ready),   64'd1);
        chk("rst_errcnt",    64'(err_count),   64'd0);
        chk("rst_rsp_data",  64'(rsp_data),    64'd0);

        // encrypt with exact latency and a single-cycle opcode pulse
        rsp_ready = 1'b1;
        push(2'b01, 16'h1234, KEY1);
        chk("t1_fifo", 64'(fifo_count), 64'd1);
        tick();
        chk("t1_opcode", 64'(core_opcode), 64'd1);
        chk("t1_cdata",  64'(core_data_in), 64'h1234);
        chk("t1_ckey",   64'(core_key), 64'(KEY1));
        chk("t1_early1", 64'(rsp_valid), 64'd0);
        tick();
        chk("t1_opcode_off", 64'(core_opcode), 64'd0);
        chk("t1_early2", 64'(rsp_valid), 64'd0);
        tick();
        chk("t1_valid", 64'(rsp_valid), 64'd1);
        check_front("t1");
        ct = rsp_data;
        chk("t1_ct", 64'(ct), 64'(spn_enc(16'h1234, KEY1)));
        tick();
        consume();
        chk("t1_done", 64'(rsp_valid), 64'd0);

        // decrypt round trip
        push(2'b10, ct, KEY1);
        take_rsp("t2");
        chk("t2_plain", 64'(last_data), 64'h1234);

        // back-pressure: five requests while the downstream stalls
        rsp_ready = 1'b0;
        for (int i = 0; i < 5; i++) push(2'(1 + (i % 2)), 16'($urandom), $urandom);
        chk("t3_fifo_full", 64'(fifo_count), 64'd4);
        chk("t3_ready_low", 64'(req_ready),  64'd0);
        chk("t3_busy",      64'(busy),       64'd1);
        for (int i = 0; i < 3; i++) begin
            chk("t3_stall_valid", 64'(rsp_valid), 64'd1);
            check_front("t3_stall");
            tick();
        end
        for (int i = 0; i < 5; i++) take_rsp("t3");
        chk("t3_drained", 64'(exp_q.size()), 64'd0);

        // illegal ops: 00 never reaches the core, 11 does
        push(2'b00, 16'hBEEF, KEY1);
        take_rsp("t4_op00");
        chk("t4_op00_pulses", 64'(pulses), 64'd0);
        chk("t4_op00_data",   64'(last_data), 64'd0);
        push(2'b11, 16'hBEEF, KEY1);
        take_rsp("t4_op11");
        chk("t4_op11_pulses", 64'(pulses), 64'd1);
        chk("t4_op11_data",   64'(last_data), 64'd0);
        chk("t4_errcnt",      64'(err_count), 64'd2);

        // core valid disagreeing with the issued op
        core_fault = 1'b1;
        push(2'b01, 16'h5A5A, KEY1);
        take_rsp("t7");
        core_fault = 1'b0;
        chk("t7_err", 64'(last_err), 64'd1);

        // saturation of the narrow counter
        for (int i = 0; i < 5; i++) begin
            push(2'b00, 16'(i), KEY1);
            take_rsp("t5");
        end
        chk("t5_sat_s",  64'(err_count_s), 64'd3);
        chk("t5_errcnt", 64'(err_count),   64'd8);

        // reset during CAPTURE with two requests queued
        push(2'b01, 16'h1111, KEY1);
        push(2'b10, 16'h2222, KEY1);
        push(2'b01, 16'h3333, KEY1);
        chk("t6_pre_fifo", 64'(fifo_count), 64'd2);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        exp_q.delete();
        errs_consumed = 0;
        chk("t6_valid",  64'(rsp_valid),   64'd0);
        chk("t6_fifo",   64'(fifo_count),  64'd0);
        chk("t6_opcode", 64'(core_opcode), 64'd0);
        chk("t6_busy",   64'(busy),        64'd0);
        chk("t6_ready",  64'(req_ready),   64'd1);
        chk("t6_errcnt", 64'(err_count),   64'd0);
        for (int i = 0; i < 6; i++) begin
            tick();
            chk("t6_no_stale", 64'(rsp_valid), 64'd0);
            chk("t6_idle_op",  64'(core_opcode), 64'd0);
        end

        // random traffic against the in-order queue model
        prev_opc = 2'b00;
        for (int c = 0; c < 2000; c++) begin
            if (rsp_valid) check_front("rnd");
            if (prev_opc != 2'b00) chk("rnd_pulse", 64'(core_opcode), 64'd0);
            chk("rnd_busy", 64'(busy), 64'(exp_q.size() != 0));
            chk("rnd_occ", 64'((exp_q.size() >= int'(fifo_count)) &&
                               (exp_q.size() - int'(fifo_count) <= 1)), 64'd1);
            chk("rnd_ready", 64'(req_ready), 64'(fifo_count != 3'(DEPTH)));
            rsp_ready = ($urandom_range(0, 9) < 7);
            req_valid = ($urandom_range(0, 1) == 1);
            r = int'($urandom_range(0, 9));
            req_op   = (r == 0) ? 2'b00 : (r == 1) ? 2'b11 : (r < 6) ? 2'b01 : 2'b10;
            req_data = 16'($urandom);
            req_key  = $urandom;
            acc      = req_valid && req_ready;
            cons     = rsp_valid && rsp_ready;
            prev_opc = core_opcode;
            tick();
            if (cons) consume();
            if (acc) exp_q.push_back(model_rsp(req_op, req_data, req_key, 1'b0));
        end

        req_valid = 1'b0;
        rsp_ready = 1'b1;
        for (int c = 0; c < 300 && exp_q.size() != 0; c++) begin
            cons = rsp_valid;
            if (rsp_valid) check_front("drain");
            tick();
            if (cons) consume();
        end
        chk("drain_left",   64'(exp_q.size()), 64'd0);
        chk("drain_busy",   64'(busy),         64'd0);
        chk("drain_fifo",   64'(fifo_count),   64'd0);
        chk("drain_ready",  64'(req_ready),    64'd1);
        chk("drain_busy_s", 64'(busy_s),       64'd0);
        chk("drain_fifo_s", 64'(fifo_count_s), 64'd0);
        chk("drain_rdy_s",  64'(req_ready_s),  64'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/spn_req_sequencer.md
Name: spn_req_sequencer

Overview:
Request front-end that sits directly upstream of the 3-round SPN core and also consumes its output.
- Buffers encrypt/decrypt requests (data plus 32-bit key) in a small FIFO.
- Issues one opcode pulse per request to the core and captures the core's registered result one cycle later.
- Presents each result on a valid/ready response port, with an error flag and a saturating error counter.
- Converts the core's free-running, unhandshaked opcode/valid interface into a flow-controlled request/response stream.

Parameters:
DEPTH, 4, request FIFO entries; power of 2, at least 2.
ERRW, 8, width of the saturating error counter.

Ports:
clk  in  1  clock.
rst  in  1  reset: one clock, synchronous, active-high; flushes all state.
req_valid  in  1  request offered.
req_ready  out  1  request accepted when req_valid and req_ready are both high.
req_op  in  2  01 = encrypt, 10 = decrypt, 00 and 11 = illegal.
req_data  in  16  plaintext or ciphertext.
req_key  in  32  symmetric secret key.
core_opcode  out  2  to core opcode; registered.
core_data_in  out  16  to core data_in; registered.
core_key  out  32  to core symmetric_secret_key; registered.
core_valid  in  2  from core valid.
core_data_out  in  16  from core data_out.
rsp_valid  out  1  response available.
rsp_ready  in  1  downstream accepts the response.
rsp_data  out  16  result; 16'h0000 on error.
rsp_op  out  2  opcode of the originating request.
rsp_err  out  1  request was illegal, or the core's valid did not match the issued opcode.
err_count  out  ERRW  saturating count of responses with rsp_err set.
fifo_count  out  $clog2(DEPTH+1)  occupancy of the request FIFO.
busy  out  1  high when state is not IDLE or fifo_count is not 0.

Behaviour:
- Reset values: all outputs 0, state IDLE, FIFO empty; req_ready is 1 in the cycle after reset.
- FIFO:
  - Each entry is {op, data, key}, 50 bits.
  - req_ready = (fifo_count != DEPTH). There is no same-cycle pass-through when full.
  - Push and pop in the same cycle leave the count unchanged.
  - Pointers wrap modulo DEPTH.
- State machine:
  - IDLE: if the FIFO is non-empty, pop the head entry.
    - Legal op: core_opcode <= op, core_data_in <= data, core_key <= key; next state ISSUE.
    - Illegal op 00: no issue to the core. Load the response with rsp_data = 0, rsp_op = 00, rsp_err = 1, rsp_valid <= 1; next state HOLD.
    - Op 11 is issued to the core like a legal op, so the core's 2'b11 reply is exercised.
  - ISSUE: opcode is driven for exactly one cycle. core_opcode <= 00; next state CAPTURE.
  - CAPTURE: sample core_valid and core_data_out; rsp_valid <= 1; next state HOLD.
    - rsp_err = 1 if the issued op is 11, or if core_valid != issued op.
    - rsp_data = core_data_out if rsp_err = 0, else 0.
    - rsp_op = issued op.
  - HOLD: rsp_data, rsp_op and rsp_err stay stable while rsp_valid && !rsp_ready. On rsp_ready: rsp_valid <= 0; next state IDLE.
- core_opcode is 00 in every state except ISSUE.
- core_data_in and core_key hold their last values between issues.
- Latency: request accepted at edge E0 → core_opcode is valid after E1 → core valid after E2 → rsp_valid high after E3. Best-case throughput is one request per 4 cycles (IDLE, ISSUE, CAPTURE, HOLD).
- err_count increments on each edge that loads rsp_err = 1 and saturates at all ones.
- Reset in the middle of an operation:
  - The FIFO and the in-flight request are discarded and rsp_valid drops.
  - A core response arriving the cycle after reset is ignored, since the state is IDLE.
  - core_opcode is 00 from the first cycle after reset.
- Pushes during HOLD back-pressure continue to be accepted until the FIFO is full. Requests are never dropped.

Test Plan:
1. Encrypt key=32'hA1B2C3D4, data=16'h1234, rsp_ready=1 → core_opcode=01 for exactly one cycle; rsp_valid 3 cycles after the accept edge; rsp_data equals the golden SPN encrypt of (16'h1234, key); rsp_err=0; rsp_op=01.
2. Feed test 1's ciphertext back as a decrypt with the same key → rsp_data=16'h1234, rsp_op=10, rsp_err=0.
3. Hold rsp_ready=0 and push 5 requests with DEPTH=4 → req_ready falls when fifo_count=4 (one request is in flight). Then release rsp_ready → 5 responses in push order; rsp_data stable while stalled.
4. Requests op=00 then op=11 → two responses with rsp_err=1 and rsp_data=0; the op=00 response never pulses core_opcode; err_count=2.
5. Saturation with ERRW=2: 5 illegal requests → err_count stays at 3.
6. Reset asserted during CAPTURE with 2 entries queued → next cycle rsp_valid=0, fifo_count=0, core_opcode=00, busy=0; no stale response afterwards.
